// File: rtl/au_gray_cnt.sv
// au_gray_cnt -- registered binary-to-Gray up/down counter.
//
// Keeps a binary count and a Gray copy of it in flops that always update on
// the same edge, so the Gray bus changes one bit per count step and can be
// sampled safely from another clock domain (e.g. FIFO pointers).
//
// Parameters:
//   WIDTH    counter width (>= 2)
//   RST_VAL  binary value loaded by reset (0 .. 2**WIDTH-1)
//   WRAP     1: wrap modulo 2**WIDTH, 0: saturate at max (up) / 0 (down)
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-high
//   en      count enable
//   dir     0: count up, 1: count down
//   ld      synchronous load of ld_val (priority over en)
//   ld_val  binary load value
//   g       registered Gray count
//   b       registered binary count
//   tc      terminal count: b == max while counting up, b == 0 while down
//   hd_err  sticky single-step violation flag
//
// Build option:
//   AU_GRAY_CNT_CHECK_EN  when defined, a step checker drives hd_err;
//                         otherwise hd_err is tied to 0.
module au_gray_cnt #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned RST_VAL = 0,
    parameter int              WRAP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b,
    output logic             tc,
    output logic             hd_err
);

    // Parameter legality, evaluated at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("au_gray_cnt: WIDTH must be >= 2");
    end
    if ((RST_VAL >> WIDTH) != 0) begin : g_bad_rst_val
        $error("au_gray_cnt: RST_VAL does not fit in WIDTH bits");
    end
    if ((WRAP != 0) && (WRAP != 1)) begin : g_bad_wrap
        $error("au_gray_cnt: WRAP must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] RST_B = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] MAX_B = '1;
    localparam logic [WIDTH-1:0] MIN_B = '0;
    localparam bit               SAT   = (WRAP == 0);

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v[WIDTH-1:1] ^ v[WIDTH-2:0]};
    endfunction

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] g_q, g_d;

    always_comb begin
        b_d = b_q;
        if (ld) begin
            b_d = ld_val;
        end else if (en) begin
            if (!dir) begin
                if (!(SAT && (b_q == MAX_B))) begin
                    b_d = b_q + 1'b1;
                end
            end else begin
                if (!(SAT && (b_q == MIN_B))) begin
                    b_d = b_q - 1'b1;
                end
            end
        end
        // Gray is encoded from the next binary value so both flops change on
        // the same edge; nothing is decoded after the flops.
        g_d = to_gray(b_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q <= RST_B;
            g_q <= to_gray(RST_B);
        end else begin
            b_q <= b_d;
            g_q <= g_d;
        end
    end

    assign b  = b_q;
    assign g  = g_q;
    // Only combinational output path: one flop compare plus the dir input.
    assign tc = dir ? (b_q == MIN_B) : (b_q == MAX_B);

`ifdef AU_GRAY_CNT_CHECK_EN
    logic [WIDTH-1:0] diff;
    logic             step_err;
    logic             hd_err_q, hd_err_d;

    // More than one bit set in diff <=> clearing the lowest set bit leaves
    // something behind.
    always_comb begin
        diff     = g_d ^ g_q;
        step_err = !ld && ((diff & (diff - 1'b1)) != '0);
        hd_err_d = hd_err_q | step_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd_err_q <= 1'b0;
        end else begin
            hd_err_q <= hd_err_d;
        end
    end

    assign hd_err = hd_err_q;
`else
    assign hd_err = 1'b0;
`endif

endmodule

// File: tb/tb_au_gray_cnt.sv
module tb_au_gray_cnt;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, dir, ld;
    logic [W-1:0] ld_val;
    logic [W-1:0] g0, b0, g1, b1;
    logic         tc0, tc1, hd0, hd1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference state: plain integers advanced by the counting rules.
    int m0, m1;
    bit hd_exp0, hd_exp1;

    always #5 clk = ~clk;

    // Wrapping counter, reset value 5.
    au_gray_cnt #(.WIDTH(W), .RST_VAL(5), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val),
        .g(g0), .b(b0), .tc(tc0), .hd_err(hd0)
    );

    // Saturating counter, reset value 0.
    au_gray_cnt #(.WIDTH(W), .RST_VAL(0), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val),
        .g(g1), .b(b1), .tc(tc1), .hd_err(hd1)
    );

    typedef struct {
        logic         ld;
        logic [W-1:0] ldv;
        logic         en;
        logic         dir;
        logic [W-1:0] b0;
        logic [W-1:0] b1;
        logic         tc0;
        logic         tc1;
    } vec_t;

    vec_t tbl[12];
    int   gseq[16];

    function automatic int model_next(int cur, bit wrap, logic l, logic [W-1:0] lv,
                                      logic e, logic d);
        if (l) return int'(lv);
        if (!e) return cur;
        if (!d) return wrap ? (cur + 1) % 16 : ((cur == 15) ? 15 : cur + 1);
        return wrap ? (cur + 15) % 16 : ((cur == 0) ? 0 : cur - 1);
    endfunction

    function automatic int model_gray(int v);
        return v ^ (v >> 1);
    endfunction

    function automatic int model_tc(int v, logic d);
        return d ? int'(v == 0) : int'(v == 15);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " wrap.b"}, 32'(b0), 32'(m0));
        chk({tag, " wrap.g"}, 32'(g0), 32'(model_gray(m0)));
        chk({tag, " wrap.tc"}, 32'(tc0), 32'(model_tc(m0, dir)));
        chk({tag, " wrap.hd_err"}, 32'(hd0), 32'(hd_exp0));
        chk({tag, " sat.b"}, 32'(b1), 32'(m1));
        chk({tag, " sat.g"}, 32'(g1), 32'(model_gray(m1)));
        chk({tag, " sat.tc"}, 32'(tc1), 32'(model_tc(m1, dir)));
        chk({tag, " sat.hd_err"}, 32'(hd1), 32'(hd_exp1));
    endtask

    // Drive inputs, take one edge, advance the model, check 1 time unit later.
    task automatic step(input string tag, input logic l, input logic [W-1:0] lv,
                        input logic e, input logic d);
        ld = l; ld_val = lv; en = e; dir = d;
        @(posedge clk);
        m0 = model_next(m0, 1'b1, l, lv, e, d);
        m1 = model_next(m1, 1'b0, l, lv, e, d);
        #1;
        check_all(tag);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        // {ld, ld_val, en, dir, exp b wrap, exp b sat, exp tc wrap, exp tc sat}
        tbl[0]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd4,  4'd0,  1'b0, 1'b1};
        tbl[1]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd3,  4'd0,  1'b0, 1'b1};
        tbl[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd4,  4'd1,  1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'd10, 1'b1, 1'b0, 4'd10, 4'd10, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd11, 4'd11, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'd14, 1'b0, 1'b0, 4'd14, 4'd14, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 4'd15, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd0,  4'd15, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd0,  4'd15, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd15, 4'd14, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  4'd0,  1'b1, 1'b1};
        tbl[11] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd15, 4'd0,  1'b0, 1'b1};
        gseq = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

        hd_exp0 = 1'b0; hd_exp1 = 1'b0;
        ld = 1'b0; ld_val = '0; en = 1'b0; dir = 1'b0;

        // Reset takes effect before any clock edge.
        rst = 1'b1;
        #2;
        m0 = 5; m1 = 0;
        chk("reset wrap.b", 32'(b0), 32'd5);
        chk("reset wrap.g", 32'(g0), 32'd7);
        chk("reset wrap.tc", 32'(tc0), 32'd0);
        chk("reset wrap.hd_err", 32'(hd0), 32'd0);
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            step($sformatf("vec%0d", i), tbl[i].ld, tbl[i].ldv, tbl[i].en, tbl[i].dir);
            chk($sformatf("vec%0d tbl wrap.b", i), 32'(b0), 32'(tbl[i].b0));
            chk($sformatf("vec%0d tbl sat.b", i), 32'(b1), 32'(tbl[i].b1));
            chk($sformatf("vec%0d tbl wrap.tc", i), 32'(tc0), 32'(tbl[i].tc0));
            chk($sformatf("vec%0d tbl sat.tc", i), 32'(tc1), 32'(tbl[i].tc1));
        end

        // Full up-count wrap through the Gray sequence.
        step("ld0", 1'b1, 4'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step($sformatf("up%0d", k), 1'b0, 4'd0, 1'b1, 1'b0);
            chk($sformatf("up%0d gray", k), 32'(g0), 32'(gseq[k % 16]));
            chk($sformatf("up%0d tc", k), 32'(tc0), 32'((k % 16) == 15));
        end

        // Saturating down-count at 0, then dir flip clears tc without an edge.
        step("ld1", 1'b1, 4'd1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step($sformatf("satdn%0d", k), 1'b0, 4'd0, 1'b1, 1'b1);
            chk($sformatf("satdn%0d b", k), 32'(b1), 32'd0);
            chk($sformatf("satdn%0d g", k), 32'(g1), 32'd0);
            chk($sformatf("satdn%0d tc", k), 32'(tc1), 32'd1);
        end
        dir = 1'b0;
        #1;
        chk("dirflip sat.tc", 32'(tc1), 32'd0);
        step("satup", 1'b0, 4'd0, 1'b1, 1'b0);
        chk("satup b", 32'(b1), 32'd1);

        // Asynchronous reset mid-cycle at b=9, then resume from reset value.
        step("ld9", 1'b1, 4'd9, 1'b0, 1'b0);
        en = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        m0 = 5; m1 = 0;
        chk("midrst wrap.b", 32'(b0), 32'd5);
        chk("midrst wrap.g", 32'(g0), 32'd7);
        check_all("midrst");
        #1;
        rst = 1'b0;
        step("resume", 1'b0, 4'd0, 1'b1, 1'b0);
        chk("resume wrap.b", 32'(b0), 32'd6);

`ifdef AU_GRAY_CNT_CHECK_EN
        // Corrupt the Gray flop so the next non-load edge is a 2-bit jump.
        step("hd ld0", 1'b1, 4'd0, 1'b0, 1'b0);
        force u_wrap.g_q = 4'b0011;
        ld = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        release u_wrap.g_q;
        hd_exp0 = 1'b1;
        chk("hd set", 32'(hd0), 32'd1);
        step("hd sticky0", 1'b0, 4'd0, 1'b1, 1'b0);
        step("hd sticky1", 1'b1, 4'd3, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        m0 = 5; m1 = 0; hd_exp0 = 1'b0;
        chk("hd cleared", 32'(hd0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            step($sformatf("rnd%0d", n), ($urandom_range(0, 9) == 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
